// File: rtl/seq_multiplier_32bit_pkg.sv
// seq_multiplier_32bit_pkg: shared widths, FSM encoding and iteration bound for the shift-add multiplier
package seq_multiplier_32bit_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = 5'd31;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/adder_32bit.sv
// adder_32bit: 32-bit ripple adder with carry-in and no carry-out
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);
  assign sum = a + b + {31'b0, cin};
endmodule

// File: rtl/seq_multiplier_32bit.sv
// seq_multiplier_32bit: unsigned 32x32->64 shift-add multiplier, one add/shift per cycle
module seq_multiplier_32bit
  import seq_multiplier_32bit_pkg::*;
#(
  parameter int WIDTH = seq_multiplier_32bit_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);
  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand, r_hi, r_lo;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic [WIDTH-1:0]   w_b, w_sum;
  logic               w_cout;
  assign w_b = r_lo[0] ? r_mcand : '0;
  adder_32bit u_add (.a(r_hi), .b(w_b), .cin(1'b0), .sum(w_sum));
  // the adder has no carry-out; recover it from the operand and sum MSBs
  assign w_cout = (r_hi[WIDTH-1] & w_b[WIDTH-1]) | ((r_hi[WIDTH-1] ^ w_b[WIDTH-1]) & ~w_sum[WIDTH-1]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_mcand <= multiplicand;
          r_hi    <= '0;
          r_lo    <= multiplier;
          r_cnt   <= '0;
          r_state <= CALC;
        end
        CALC: begin
          r_hi  <= {w_cout, w_sum[WIDTH-1:1]};
          r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_state   <= DONE;
            r_product <= {w_cout, w_sum, r_lo[WIDTH-1:1]};
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign product = r_product;
  assign busy    = (r_state == CALC);
  assign done    = (r_state == DONE);
endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// tb_seq_multiplier_32bit: directed and regression stimulus with a queue scoreboard on done strobes
module tb_seq_multiplier_32bit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic [63:0] product;
  logic        busy, done;
  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  seq_multiplier_32bit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .multiplicand(multiplicand),
    .multiplier(multiplier), .product(product), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  // monitor: pops on every done strobe, otherwise product must hold
  initial begin
    logic [63:0] last;
    last = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) last = '0;
      else if (done) begin
        if (exp_q.size() == 0) check("unexpected_done", product, last);
        else check("product", product, exp_q.pop_front());
        last = product;
      end else check("product_stable", product, last);
    end
  end
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
    @(negedge clk);
    multiplicand = a; multiplier = b; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (33) @(negedge clk);
  endtask
  initial begin
    int k, nbusy;
    logic [31:0] a, b;
    #12;
    check("rst_product", product, 64'h0);
    check("rst_busy", {63'b0, busy}, 64'h0);
    check("rst_done", {63'b0, done}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // 3x5: done must appear 33 cycles after start is driven, busy for 32 of them
    @(negedge clk);
    multiplicand = 32'd3; multiplier = 32'd5; start = 1'b1;
    exp_q.push_back(64'h0000_0000_0000_000F);
    k = 0; nbusy = 0;
    while (k < 50) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (done) break;
      if (busy) nbusy++;
    end
    check("latency", 64'(k), 64'd33);
    check("busy_cycles", 64'(nbusy), 64'd32);
    repeat (2) @(negedge clk);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    op(32'h0000_0000, 32'hDEAD_BEEF, 64'h0);
    op(32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000);
    op(32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF);
    op(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    op(32'h0000_0001, 32'h0000_0001, 64'h1);
    // start during CALC and during DONE is ignored; the following IDLE start is taken
    @(negedge clk);
    multiplicand = 32'd100; multiplier = 32'd3; start = 1'b1;
    exp_q.push_back(64'd300);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    multiplicand = 32'd5; multiplier = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (21) @(negedge clk);
    check("done_cycle", {63'b0, done}, 64'h1);
    multiplicand = 32'd6; multiplier = 32'd6; start = 1'b1;
    @(negedge clk);
    multiplicand = 32'd11; multiplier = 32'd13;
    exp_q.push_back(64'd143);
    @(negedge clk);
    start = 1'b0;
    repeat (34) @(negedge clk);
    // back-to-back regression with start held high
    start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom;
      if (i % 50 == 0) a = 32'hFFFF_FFFF;
      multiplicand = a; multiplier = b;
      exp_q.push_back({32'b0, a} * {32'b0, b});
      repeat (34) @(negedge clk);
    end
    start = 1'b0;
    repeat (36) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    // asynchronous reset mid-CALC discards the operation
    @(negedge clk);
    multiplicand = 32'h0000_1234; multiplier = 32'h0000_0010; start = 1'b1;
    exp_q.push_back(64'h0000_0000_0001_2340);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {63'b0, busy}, 64'h0);
    check("mid_rst_done", {63'b0, done}, 64'h0);
    check("mid_rst_product", product, 64'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    op(32'd7, 32'd9, 64'd63);
    repeat (5) @(negedge clk);
    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
